// File: rtl/alu_serial_seq_if.sv
// Request/response bundle for the bit-serial ALU: operand handshake in,
// registered result handshake out.
interface alu_serial_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  modport master (
    output in_valid, src1, src2, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow
  );

  modport slave (
    input  in_valid, src1, src2, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial 32-bit ALU: one 1-bit slice walked LSB first over 32 RUN cycles.
// Define ALU_SERIAL_OVF_EN to compute signed overflow and overflow-corrected SLT.
module alu_serial_seq (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_serial_seq_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic       cin0;
    logic [1:0] op;
    logic       arith;
    logic       slt;
    logic       legal;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] ctrl);
    dec_t d;
    d = '0;
    case (ctrl)
      4'b0000: begin d.op = OP_AND; d.legal = 1'b1; end
      4'b0001: begin d.op = OP_OR;  d.legal = 1'b1; end
      4'b0010: begin d.op = OP_ADD; d.arith = 1'b1; d.legal = 1'b1; end
      4'b0110: begin
        d.op = OP_ADD; d.b_inv = 1'b1; d.cin0 = 1'b1; d.arith = 1'b1; d.legal = 1'b1;
      end
      4'b0111: begin
        d.op = OP_ADD; d.b_inv = 1'b1; d.cin0 = 1'b1; d.arith = 1'b1;
        d.slt = 1'b1; d.legal = 1'b1;
      end
      4'b1100: begin
        d.op = OP_AND; d.a_inv = 1'b1; d.b_inv = 1'b1; d.legal = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_last;
  logic        r_carry;
  logic [31:0] r_a;
  logic [31:0] r_b;
  dec_t        r_dec;
  logic [31:0] r_shift;
  logic [31:0] r_result;
  logic        r_cout;
  logic        r_ovf;
  logic        r_cout_s;
  logic        r_ovf_s;

  dec_t        w_dec_in;
  logic        w_a;
  logic        w_b;
  logic        w_sum;
  logic        w_cout;
  logic        w_bit;
  logic        w_ovf;
  logic        w_slt;

  assign w_dec_in = decode(bus.alu_ctrl);

  // The single 1-bit slice, fed by the controller-selected operand bit.
  assign w_a    = r_a[r_cnt] ^ r_dec.a_inv;
  assign w_b    = r_b[r_cnt] ^ r_dec.b_inv;
  assign w_sum  = w_a ^ w_b ^ r_carry;
  assign w_cout = (w_a & w_b) | (r_carry & (w_a ^ w_b));

  always_comb begin
    w_bit = 1'b0;
    if (r_dec.legal) begin
      case (r_dec.op)
        OP_AND:  w_bit = w_a & w_b;
        OP_OR:   w_bit = w_a | w_b;
        OP_ADD:  w_bit = w_sum;
        default: w_bit = 1'b0;
      endcase
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  assign w_ovf = r_dec.arith & (r_carry ^ w_cout);
`else
  assign w_ovf = 1'b0;
`endif
  assign w_slt = w_sum ^ w_ovf;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_next = ST_RUN;
      ST_RUN:  if (r_last)        w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = (r_result == 32'd0);
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make update order matter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_last   <= 1'b0;
      r_carry  <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_dec    <= '0;
      r_shift  <= 32'd0;
      r_result <= 32'd0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cout_s <= 1'b0;
      r_ovf_s  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.src1;
            r_b     <= bus.src2;
            r_dec   <= w_dec_in;
            r_cnt   <= 5'd0;
            r_last  <= 1'b0;
            r_carry <= w_dec_in.cin0;
          end
        end
        ST_RUN: begin
          if (!r_last) begin
            if (r_cnt == 5'd31 && r_dec.slt) r_shift <= {31'd0, w_slt};
            else                             r_shift <= {w_bit, r_shift[31:1]};
            if (r_dec.arith) r_carry <= w_cout;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_last   <= 1'b1;
              r_cout_s <= r_dec.arith & w_cout;
              r_ovf_s  <= w_ovf;
            end
          end else begin
            // Commit all flags together so the result never appears partially.
            r_result <= r_shift;
            r_cout   <= r_cout_s;
            r_ovf    <= r_ovf_s;
            r_last   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed-vector bench for alu_serial_seq; expectations follow the
// ALU_SERIAL_OVF_EN setting of the build.
module tb_alu_serial_seq;

  logic clk_i = 1'b0;
  logic rst_i;

  alu_serial_seq_if bus ();

  alu_serial_seq dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

`ifdef ALU_SERIAL_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        o;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input vec_t v, output int lat);
    @(negedge clk_i);
    check({v.name, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.src1     = v.a;
    bus.src2     = v.b;
    bus.alu_ctrl = v.ctrl;
    @(posedge clk_i);
    @(negedge clk_i);
    check({v.name, "_in_ready_run"}, 32'(bus.in_ready), 32'd0);
    bus.src1     = ~v.a;
    bus.src2     = ~v.b;
    bus.alu_ctrl = ~v.ctrl;
    wait_done(lat);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input int lat);
    check({v.name, "_latency"},  32'(lat),          32'd33);
    check({v.name, "_result"},   bus.result,        v.res);
    check({v.name, "_zero"},     32'(bus.zero),     32'(v.res == 32'd0));
    check({v.name, "_cout"},     32'(bus.cout),     32'(v.c));
    check({v.name, "_overflow"}, 32'(bus.overflow), 32'(v.o));
  endtask

  task automatic release_op(input vec_t v);
    bus.out_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.out_ready = 1'b0;
    check({v.name, "_idle_valid"},  32'(bus.out_valid), 32'd0);
    check({v.name, "_idle_ready"},  32'(bus.in_ready),  32'd1);
    check({v.name, "_idle_result"}, bus.result,         v.res);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   seen;
    vec_t bb;

    vecs[0] = '{"add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, OVF};
    vecs[1] = '{"sub_eq",  4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{"slt_neg", 4'b0111, 32'h8000_0000, 32'h0000_0001, OVF ? 32'd1 : 32'd0, 1'b1, OVF};
    vecs[3] = '{"slt_pos", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, OVF ? 32'd0 : 32'd1, 1'b0, OVF};
    vecs[4] = '{"and",     4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0};
    vecs[5] = '{"or",      4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6] = '{"add_wrap",4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{"unsup",   4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8] = '{"nor",     4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 1'b0};
    bb      = '{"b2b_add", 4'b0010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};

    rst_i         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    bus.alu_ctrl  = 4'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_zero",      32'(bus.zero),      32'd1);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    rst_i = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_op(vecs[k], lat);
      check_result(vecs[k], lat);
      if (k == 0) begin
        for (int s = 0; s < 5; s++) begin
          @(posedge clk_i);
          @(negedge clk_i);
          check("hold_valid",  32'(bus.out_valid), 32'd1);
          check("hold_result", bus.result,         vecs[0].res);
        end
      end
      release_op(vecs[k]);
    end

    // NOR, then a back-to-back request with out_ready held high.
    run_op(vecs[8], lat);
    check_result(vecs[8], lat);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.src1      = bb.a;
    bus.src2      = bb.b;
    bus.alu_ctrl  = bb.ctrl;
    check("b2b_done_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("b2b_idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("b2b_idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("b2b_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_done(lat);
    check_result(bb, lat);
    release_op(bb);

    // ADD 1+1, reset asserted while bit 10 is being processed.
    @(negedge clk_i);
    bus.in_valid = 1'b1;
    bus.src1     = 32'd1;
    bus.src2     = 32'd1;
    bus.alu_ctrl = 4'b0010;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_i         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rrun_in_ready",  32'(bus.in_ready),  32'd1);
    check("rrun_out_valid", 32'(bus.out_valid), 32'd0);
    check("rrun_result",    bus.result,         32'd0);
    check("rrun_zero",      32'(bus.zero),      32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (bus.out_valid) seen++;
    end
    check("rrun_no_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
